// File: rtl/country_road_sensor_if.sv
// Country-road detector bundle: raw sensor and light state in, queue status out.
// The sensor block drives the slave side, the traffic controller the master side.
interface country_road_sensor_if #(
    parameter int CW = 4
);
    logic          sensor_raw;
    logic [1:0]    cntry;
    logic          X;
    logic [CW-1:0] car_count;
    logic          overflow;

    modport master (
        output sensor_raw, cntry,
        input  X, car_count, overflow
    );

    modport slave (
        input  sensor_raw, cntry,
        output X, car_count, overflow
    );
endinterface

// File: rtl/country_road_sensor.sv
// Country-road loop detector conditioning: synchronizer, debounce FSM,
// and a saturating car queue that drains while the country light is green.
module country_road_sensor #(
    parameter int DEBOUNCE    = 4,
    parameter int PASS_CYCLES = 3,
    parameter int MAX_CARS    = 15,
    parameter int CW          = 4
) (
    input logic                  clock,
    input logic                  clear_n,
    country_road_sensor_if.slave bus
);
    localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int PTW = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
    localparam logic [PTW-1:0] PT_LAST = PTW'(PASS_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_CARS);

    typedef enum logic [1:0] {
        IDLE,
        RISE_CHK,
        PRESENT,
        FALL_CHK
    } state_t;

    state_t         state_q, state_d;
    logic [DBW-1:0] db_q, db_d;
    logic [PTW-1:0] pt_q, pt_d;
    logic [CW-1:0]  count_q, count_d;
    logic           s1_q, s2_q;
    logic           x_q;
    logic           ovf_q, ovf_d;
    logic           arrival;
    logic           depart;
    logic           draining;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE;
            db_q    <= '0;
            pt_q    <= '0;
            count_q <= '0;
            x_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            s1_q    <= bus.sensor_raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            db_q    <= db_d;
            pt_q    <= pt_d;
            count_q <= count_d;
            x_q     <= (count_d != '0);
            ovf_q   <= ovf_d;
        end
    end

    // With DEBOUNCE == 1 the first sampled level is already accepted.
    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        arrival = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s2_q) begin
                    if (DEBOUNCE == 1) begin
                        state_d = PRESENT;
                        arrival = 1'b1;
                    end else begin
                        state_d = RISE_CHK;
                        db_d    = DBW'(1);
                    end
                end
            end
            RISE_CHK: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    db_d    = '0;
                end else if (db_q == DB_LAST) begin
                    state_d = PRESENT;
                    db_d    = '0;
                    arrival = 1'b1;
                end else begin
                    db_d = db_q + DBW'(1);
                end
            end
            PRESENT: begin
                if (!s2_q) begin
                    if (DEBOUNCE == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FALL_CHK;
                        db_d    = DBW'(1);
                    end
                end
            end
            FALL_CHK: begin
                if (s2_q) begin
                    state_d = PRESENT;
                    db_d    = '0;
                end else if (db_q == DB_LAST) begin
                    state_d = IDLE;
                    db_d    = '0;
                end else begin
                    db_d = db_q + DBW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                db_d    = '0;
            end
        endcase
    end

    // Leaving green or an empty queue discards partial pass progress.
    always_comb begin
        draining = (bus.cntry == 2'd2) && (count_q != '0);
        depart   = draining && (pt_q == PT_LAST);
        pt_d     = '0;
        if (draining && !depart) begin
            pt_d = pt_q + PTW'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (arrival && !depart) begin
            if (count_q < CNT_MAX) begin
                count_d = count_q + CW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (depart && !arrival) begin
            count_d = count_q - CW'(1);
        end
    end

    assign bus.X         = x_q;
    assign bus.car_count = count_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_country_road_sensor.sv
// Directed scoreboard bench for the country-road sensor: expected queue
// state is pushed when stimulus is applied and popped at each check point.
module tb_country_road_sensor;
    logic clock;
    logic clear_n;

    country_road_sensor_if #(.CW(4)) bus ();

    country_road_sensor dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    typedef struct {
        string      tag;
        logic       x;
        logic [3:0] cnt;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input string tag, input logic x,
                        input logic [3:0] c, input logic o);
        exp_t e;
        e.tag = tag;
        e.x   = x;
        e.cnt = c;
        e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e = sb.pop_front();
            assert (bus.X === e.x && bus.car_count === e.cnt &&
                    bus.overflow === e.ovf)
            else begin
                errors++;
                $error("FAIL %s: observed X=%b cnt=%0d ovf=%b expected X=%b cnt=%0d ovf=%b",
                       e.tag, bus.X, bus.car_count, bus.overflow,
                       e.x, e.cnt, e.ovf);
            end
        end
    endtask

    task automatic car();
        bus.sensor_raw = 1'b1;
        tick(10);
        bus.sensor_raw = 1'b0;
        tick(10);
    endtask

    initial begin
        clear_n        = 1'b1;
        bus.sensor_raw = 1'b0;
        bus.cntry      = 2'd0;

        // Reset state
        #2 clear_n = 1'b0;
        push("reset_init", 1'b0, 4'd0, 1'b0);
        #1 check();
        tick(2);
        clear_n = 1'b1;

        // Short glitch is rejected
        push("glitch", 1'b0, 4'd0, 1'b0);
        bus.sensor_raw = 1'b1;
        tick(2);
        bus.sensor_raw = 1'b0;
        tick(10);
        check();

        // Clean arrival lands on edge 6
        push("arr_edge5", 1'b0, 4'd0, 1'b0);
        push("arr_edge6", 1'b1, 4'd1, 1'b0);
        bus.sensor_raw = 1'b1;
        tick(5);
        check();
        tick(1);
        check();
        tick(4);
        bus.sensor_raw = 1'b0;
        tick(10);
        push("second_car", 1'b1, 4'd2, 1'b0);
        car();
        check();

        // Bounce inside a long pulse counts once
        push("bounce", 1'b1, 4'd3, 1'b0);
        bus.sensor_raw = 1'b1;
        tick(5);
        bus.sensor_raw = 1'b0;
        tick(1);
        bus.sensor_raw = 1'b1;
        tick(4);
        bus.sensor_raw = 1'b0;
        tick(10);
        check();

        // Async reset mid-debounce, then full latency again
        push("reset_async", 1'b0, 4'd0, 1'b0);
        bus.sensor_raw = 1'b1;
        tick(3);
        #2 clear_n = 1'b0;
        #1 check();
        tick(1);
        clear_n = 1'b1;
        push("post_rst_e5", 1'b0, 4'd0, 1'b0);
        push("post_rst_e6", 1'b1, 4'd1, 1'b0);
        tick(5);
        check();
        tick(1);
        check();
        tick(4);
        bus.sensor_raw = 1'b0;
        tick(10);

        // Drain two cars under green
        push("pre_drain", 1'b1, 4'd2, 1'b0);
        car();
        check();
        push("drain_e2", 1'b1, 4'd2, 1'b0);
        push("drain_e3", 1'b1, 4'd1, 1'b0);
        push("drain_e5", 1'b1, 4'd1, 1'b0);
        push("drain_e6", 1'b0, 4'd0, 1'b0);
        push("no_underflow", 1'b0, 4'd0, 1'b0);
        bus.cntry = 2'd2;
        tick(2);
        check();
        tick(1);
        check();
        tick(2);
        check();
        tick(1);
        check();
        tick(10);
        check();
        bus.cntry = 2'd0;

        // Yellow discards partial pass progress
        push("yel_arrive", 1'b1, 4'd1, 1'b0);
        car();
        check();
        push("yel_hold", 1'b1, 4'd1, 1'b0);
        push("regreen_e2", 1'b1, 4'd1, 1'b0);
        push("regreen_e3", 1'b0, 4'd0, 1'b0);
        bus.cntry = 2'd2;
        tick(2);
        bus.cntry = 2'd1;
        tick(5);
        check();
        bus.cntry = 2'd2;
        tick(2);
        check();
        tick(1);
        check();
        bus.cntry = 2'd0;

        // Arrival coincident with departure leaves count unchanged
        push("sim_pre", 1'b1, 4'd1, 1'b0);
        car();
        check();
        push("sim_e5", 1'b1, 4'd1, 1'b0);
        push("sim_e6", 1'b1, 4'd1, 1'b0);
        push("sim_after", 1'b1, 4'd1, 1'b0);
        bus.sensor_raw = 1'b1;
        tick(3);
        bus.cntry = 2'd2;
        tick(2);
        check();
        tick(1);
        check();
        bus.cntry = 2'd0;
        tick(3);
        bus.sensor_raw = 1'b0;
        tick(10);
        check();

        // Saturation and sticky overflow
        push("sat_reset", 1'b0, 4'd0, 1'b0);
        clear_n = 1'b0;
        #2 check();
        tick(1);
        clear_n = 1'b1;
        push("sat_15", 1'b1, 4'd15, 1'b0);
        push("sat_16", 1'b1, 4'd15, 1'b1);
        push("ovf_sticky", 1'b0, 4'd0, 1'b1);
        push("ovf_cleared", 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            car();
        end
        check();
        car();
        check();
        bus.cntry = 2'd2;
        tick(50);
        check();
        bus.cntry = 2'd0;
        clear_n = 1'b0;
        #1 check();
        tick(1);
        clear_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
